// File: rtl/fetch_pc_ctrl.sv
// Program counter and fetch-redirect controller: owns the PC, applies EX-stage
// redirects, squashes wrong-path IF/ID and ID/EX contents, and handles halt/trap.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic             jump,
  input  logic [31:0]      target,
  input  logic             halt_req,
  input  logic             resume,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             halted,
  output logic             misaligned,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  state_t state;
  logic   redirect;
  logic   accept;
  logic   target_aligned;
  logic   cnt_full;

  assign redirect       = br_taken | jump;
  assign accept         = (state == ST_RUN) & ~rst;
  assign target_aligned = (target[1:0] == 2'b00);
  assign cnt_full       = (redirect_cnt == {CNT_W{1'b1}});

  // Flushes are combinational so the wrong-path instructions are squashed at
  // the same edge that loads the redirect target or enters HALT/TRAP.
  assign flush_ifid = accept & (redirect | halt_req);
  assign flush_idex = accept & (redirect | halt_req);

  assign pc_plus4   = pc + 32'd4;
  assign halted     = (state == ST_HALT);
  assign misaligned = (state == ST_TRAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      pc           <= RESET_PC;
      redirect_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect) begin
            if (target_aligned) begin
              pc <= target;
              if (!cnt_full) redirect_cnt <= redirect_cnt + CNT_W'(1);
            end else begin
              state <= ST_TRAP;
            end
          end else if (halt_req) begin
            state <= ST_HALT;
          end else if (!stall) begin
            pc <= pc_plus4;
          end
        end
        // PC stays put on the resume edge; fetch advances on the next cycle.
        ST_HALT: begin
          if (resume) state <= ST_RUN;
        end
        ST_TRAP: begin
          state <= ST_TRAP;
        end
        default: begin
          state <= ST_TRAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios plus random traffic, checked by a
// queue-based scoreboard fed from a rule-level reference model.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fi;
    logic        fe;
    logic        h;
    logic        m;
    logic [15:0] c16;
    logic [1:0]  c2;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0, br_taken = 1'b0, jump = 1'b0;
  logic        halt_req = 1'b0, resume = 1'b0;
  logic [31:0] target = 32'h0;

  logic [31:0] pc, pc_plus4;
  logic        flush_ifid, flush_idex, halted, misaligned;
  logic [15:0] redirect_cnt;

  logic [31:0] pc_s, pc_plus4_s;
  logic        flush_ifid_s, flush_idex_s, halted_s, misaligned_s;
  logic [1:0]  redirect_cnt_s;

  fetch_pc_ctrl #(.RESET_PC(RST_PC), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .jump(jump),
    .target(target), .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_plus4(pc_plus4), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .halted(halted), .misaligned(misaligned),
    .redirect_cnt(redirect_cnt)
  );

  fetch_pc_ctrl #(.RESET_PC(RST_PC), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .jump(jump),
    .target(target), .halt_req(halt_req), .resume(resume),
    .pc(pc_s), .pc_plus4(pc_plus4_s), .flush_ifid(flush_ifid_s),
    .flush_idex(flush_idex_s), .halted(halted_s), .misaligned(misaligned_s),
    .redirect_cnt(redirect_cnt_s)
  );

  // reference model, expressed as architectural rules
  bit          m_valid = 1'b0;
  bit          m_halt, m_trap;
  logic [31:0] m_pc;
  int          m_cnt;

  // scoreboard
  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_t'(exp_q.pop_front());
      chk("pc",           pc,                  e.pc);
      chk("pc_plus4",     pc_plus4,            e.pc4);
      chk("flush_ifid",   {31'd0, flush_ifid}, {31'd0, e.fi});
      chk("flush_idex",   {31'd0, flush_idex}, {31'd0, e.fe});
      chk("halted",       {31'd0, halted},     {31'd0, e.h});
      chk("misaligned",   {31'd0, misaligned}, {31'd0, e.m});
      chk("redirect_cnt", {16'd0, redirect_cnt}, {16'd0, e.c16});
      chk("sat_cnt",      {30'd0, redirect_cnt_s}, {30'd0, e.c2});
      chk("sat_pc",       pc_s,                e.pc);
    end
  end

  // driver: apply one cycle of inputs, push expected outputs, advance model
  task automatic cycle(input bit r, input bit s, input bit b, input bit j,
                       input logic [31:0] t, input bit h, input bit res);
    exp_t e;
    bit   acc;
    rst = r; stall = s; br_taken = b; jump = j; target = t;
    halt_req = h; resume = res;
    if (m_valid) begin
      acc   = !r && !m_halt && !m_trap;
      e.pc  = m_pc;
      e.pc4 = m_pc + 32'd4;
      e.fi  = acc && (b || j || h);
      e.fe  = acc && (b || j || h);
      e.h   = m_halt;
      e.m   = m_trap;
      e.c16 = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
      e.c2  = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
      exp_q.push_back(EXP_W'(e));
    end
    @(posedge clk);
    if (r) begin
      m_valid = 1'b1; m_pc = RST_PC; m_halt = 1'b0; m_trap = 1'b0; m_cnt = 0;
    end else if (m_valid) begin
      if (m_trap) begin
        // frozen until reset
      end else if (m_halt) begin
        if (res) m_halt = 1'b0;
      end else if (b || j) begin
        if (t % 4 == 0) begin
          m_pc = t;
          m_cnt++;
        end else begin
          m_trap = 1'b1;
        end
      end else if (h) begin
        m_halt = 1'b1;
      end else if (!s) begin
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    logic [31:0] t;
    #1;
    cycle(1, 0, 0, 0, 32'h0, 0, 0);
    cycle(1, 0, 0, 0, 32'h0, 0, 0);
    // free run from reset
    idle(2);
    // redirect beats a simultaneous stall
    cycle(0, 1, 1, 0, 32'h0000_0040, 0, 0);
    idle(2);
    // misaligned jump traps; everything but reset is ignored afterwards
    cycle(0, 0, 0, 1, 32'h0000_0202, 0, 0);
    cycle(0, 0, 1, 0, 32'h0000_0300, 0, 0);
    cycle(0, 0, 0, 0, 32'h0, 0, 1);
    cycle(0, 1, 0, 0, 32'h0, 1, 0);
    cycle(1, 0, 1, 0, 32'h0000_0400, 0, 0);
    idle(1);
    // halt at 0x200, ignore branches, then resume
    cycle(0, 0, 1, 0, 32'h0000_0200, 0, 0);
    cycle(0, 0, 0, 0, 32'h0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, i[0], i[0], 0, 32'h0000_0800, 1, 0);
    cycle(0, 0, 0, 0, 32'h0, 0, 1);
    idle(2);
    // resume in RUN has no effect; halt_req dropped under a redirect
    cycle(0, 0, 0, 0, 32'h0, 0, 1);
    cycle(0, 0, 1, 1, 32'h0000_0010, 1, 0);
    idle(1);
    // wrap-around at the top of the address space
    cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    idle(3);
    // counter saturation on the narrow instance
    cycle(1, 0, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 32'h0000_1000 + 32'(i * 16), 0, 0);
    idle(1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      t = $urandom();
      case ($urandom_range(0, 7))
        0:       ;
        1:       t = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFC : 32'hFFFF_FFF8;
        default: t[1:0] = 2'b00;
      endcase
      cycle($urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 12,
            $urandom_range(0, 99) < 6,
            t,
            $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 20);
    end
    idle(1);
    repeat (3) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Program-counter and fetch-redirect controller. It sits directly downstream of the branch control unit. It consumes the resolved branch decision (`Br_anded`) and jump indications from the EX stage. It owns the PC register, selects the next fetch address and squashes the wrong-path instructions held in the IF/ID and ID/EX pipeline registers. It also implements halt/resume and a misaligned-target trap, and keeps a saturating count of taken redirects for performance monitoring.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `CNT_W`, default 16: width of the redirect counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  load-use stall from the hazard unit; holds the PC.
- `br_taken`  in  1  `Br_anded` from the branch control unit (EX stage).
- `jump`  in  1  JAL/JALR resolved in EX.
- `target`  in  32  branch/jump target computed in EX.
- `halt_req`  in  1  ECALL/EBREAK reached EX; request halt.
- `resume`  in  1  leave HALT state.
- `pc`  out  32  current fetch address (registered).
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `flush_ifid`  out  1  squash the IF/ID register at the next edge.
- `flush_idex`  out  1  squash the ID/EX register at the next edge.
- `halted`  out  1  high while in HALT.
- `misaligned`  out  1  high while in TRAP.
- `redirect_cnt`  out  CNT_W  saturating count of accepted redirects.

## Operation
State machine has three states: RUN, HALT and TRAP. The reset state is RUN.
- `redirect = br_taken | jump`. It is evaluated only in RUN.
- Priority in RUN, highest first:
  - `rst`
  - redirect
  - `halt_req`
  - `stall`
  - normal increment
- RUN, redirect with `target[1:0] == 0`:
  - `pc <= target`.
  - `flush_ifid = flush_idex = 1` in the same cycle.
  - `redirect_cnt` increments.
  - Stays in RUN.
- RUN, redirect with `target[1:0] != 0`:
  - Enter TRAP; `pc` holds.
  - Both flushes asserted in that cycle.
  - Counter unchanged.
- RUN, `halt_req` with no redirect:
  - Enter HALT; `pc` holds.
  - `flush_idex = 1` (squashes the instruction following the halting one); `flush_ifid = 1`.
- RUN, `stall` only: `pc` holds, flushes 0.
- RUN, otherwise: `pc <= pc + 4`. Wrap-around is required: 32'hFFFF_FFFC → 32'h0000_0000.
- HALT:
  - `pc` frozen; flushes 0.
  - `br_taken`, `jump`, `halt_req` and `stall` are ignored.
  - `resume=1` → RUN at the next edge, with `pc` unchanged at that edge. Increment resumes on the following cycle.
- TRAP:
  - `pc` frozen; flushes 0; all inputs ignored.
  - Exit only through `rst`.
- `redirect_cnt` saturates at all-ones; it never wraps.
- `flush_ifid`, `flush_idex` and `pc_plus4` are combinational. `halted` and `misaligned` are decodes of the state register.

## Timing
- Reset values:
  - `pc = RESET_PC`
  - `pc_plus4 = RESET_PC + 4`
  - `flush_ifid = flush_idex = 0`
  - `halted = 0`, `misaligned = 0`
  - `redirect_cnt = 0`
  - state = RUN
- Reset applied mid-operation (any state, any inputs) takes effect at the next edge. It overrides a redirect, halt or stall in the same cycle.
- Redirect latency is one cycle. The target appears on `pc` the cycle after `br_taken`/`jump`. Flushes are valid in the same cycle as the request, so the wrong-path instructions are squashed at that same edge.
- A redirect in the same cycle as `stall` wins: the PC loads the target and flushes are asserted.
- `br_taken` and `jump` asserted together are treated as a single redirect; the counter increments by 1.
- `halt_req` in the same cycle as a redirect is dropped; the redirect wins.
- `resume` asserted in RUN or TRAP has no effect.
- Flushes never assert outside the cycle of an accepted redirect, trap entry or halt entry.

## Test plan
- Reset then free-run 4 cycles with `RESET_PC = 0x100`:
  - `pc` reads 0x100, 0x104, 0x108, 0x10C, 0x110.
  - Flushes stay 0; `redirect_cnt = 0`.
- At `pc = 0x108`, pulse `br_taken=1`, `target=0x040`, with `stall=1` in the same cycle:
  - Both flushes are 1 that cycle.
  - Next cycle `pc = 0x040`, then 0x044.
  - `redirect_cnt = 1`.
- Pulse `jump=1`, `target=0x0000_0202`:
  - Flushes are 1 that cycle.
  - Next cycle `misaligned=1`, `pc` is unchanged.
  - Further `br_taken`, `resume` and `stall` leave `pc` frozen.
  - `rst` returns to `RESET_PC` with `misaligned=0`.
- At `pc = 0x200`, assert `halt_req`:
  - `halted=1` next cycle; `pc` holds 0x200 while `br_taken` toggles.
  - Assert `resume`: `halted=0` next cycle, `pc` still 0x200, then 0x204.
- Force `pc = 0xFFFF_FFFC` via a redirect, then run 2 cycles: `pc` becomes 0x0000_0000, then 0x0000_0004.
- With `CNT_W = 2`, issue 5 aligned redirects: `redirect_cnt` reads 1, 2, 3, 3, 3.
